// File: rtl/dht22_pkg.sv
// Shared types and constants for the DHT22 single-wire protocol engine.
// Holds the FSM state type, frame layout constants and the checksum helper.
package dht22_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_LOW,
        ST_WAIT_ACK,
        ST_ACK_LOW,
        ST_ACK_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK
    } dht22_state_e;

    // Default ACLK; parameterised tops derive their own ratio via cyc_per_us().
    localparam int DEFAULT_CLK_FREQ_HZ = 100_000_000;
    localparam int CYC_PER_US          = DEFAULT_CLK_FREQ_HZ / 1_000_000;

    localparam int FRAME_W      = 40;
    localparam int LAST_BIT_IDX = FRAME_W - 1;
    localparam int BYTE4_MSB    = 39;
    localparam int BYTE3_MSB    = 31;
    localparam int BYTE2_MSB    = 23;
    localparam int BYTE1_MSB    = 15;
    localparam int BYTE0_MSB    = 7;
    localparam int HUM_MSB      = BYTE4_MSB;
    localparam int TEMP_MSB     = BYTE2_MSB;

    function automatic int cyc_per_us(input int clk_freq_hz);
        return clk_freq_hz / 1_000_000;
    endfunction

    function automatic logic frame_csum_ok(input logic [FRAME_W-1:0] f);
        logic [7:0] sum;
        sum = f[BYTE4_MSB -: 8] + f[BYTE3_MSB -: 8] + f[BYTE2_MSB -: 8] + f[BYTE1_MSB -: 8];
        return sum == f[BYTE0_MSB -: 8];
    endfunction

endpackage

// File: rtl/dht22_us_tick.sv
// Microsecond prescaler: one-cycle tick every CYC_PER_US clocks.
// A synchronous clear restarts the period so each FSM state measures from zero.
module dht22_us_tick #(
    parameter int CYC_PER_US = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYC_PER_US - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST) && !clr;
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dht22_onewire_ctrl.sv
// DHT22 single-wire engine: start pulse, 40-bit frame decode, checksum check.
// Optional macro DHT22_GLITCH_FILTER_EN adds a 3-sample majority filter on the pad.
module dht22_onewire_ctrl
    import dht22_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int START_LOW_US  = 1000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 48
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        checksum_ok,
    output logic        timeout_err,
    input  logic        dht_i,
    output logic        dht_oe
);

    localparam int          US_CYC        = cyc_per_us(CLK_FREQ_HZ);
    localparam logic [15:0] START_LOW_CNT = 16'(START_LOW_US);
    localparam logic [15:0] TIMEOUT_CNT   = 16'(TIMEOUT_US);
    localparam logic [15:0] THRESH_CNT    = 16'(BIT_THRESH_US);

    logic sync1_q, sync2_q, line, line_prev_q, rise, fall;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= dht_i;
            sync2_q     <= sync1_q;
            line_prev_q <= line;
        end
    end

`ifdef DHT22_GLITCH_FILTER_EN
    logic hist1_q, hist2_q, filt_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
            filt_q  <= 1'b1;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            filt_q  <= (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
        end
    end

    assign line = filt_q;
`else
    assign line = sync2_q;
`endif

    assign rise = line & ~line_prev_q;
    assign fall = ~line & line_prev_q;

    dht22_state_e       state_q, state_d;
    logic [15:0]        us_cnt_q, us_cnt_d;
    logic [5:0]         idx_q, idx_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [15:0]        hum_q, hum_d, temp_q, temp_d;
    logic               ck_q, ck_d, to_q, to_d, done_q, done_d;
    logic               state_chg, tick, csum_pass;

    assign state_chg = (state_d != state_q);
    assign csum_pass = frame_csum_ok(frame_q);

    dht22_us_tick #(.CYC_PER_US(US_CYC)) u_tick (
        .clk  (ACLK),
        .rst  (ARESET),
        .clr  (state_chg),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        hum_d   = hum_q;
        temp_d  = temp_q;
        ck_d    = ck_q;
        to_d    = to_q;
        done_d  = 1'b0;
        unique case (state_q)
            // done_q still high means the previous transaction is being reported
            ST_IDLE:      if (start && !done_q) state_d = ST_START_LOW;
            ST_START_LOW: if (us_cnt_q >= START_LOW_CNT) state_d = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (fall) state_d = ST_ACK_LOW;
            ST_ACK_LOW:   if (rise) state_d = ST_ACK_HIGH;
            ST_ACK_HIGH: begin
                idx_d = '0;
                if (fall) state_d = ST_BIT_LOW;
            end
            ST_BIT_LOW:   if (rise) state_d = ST_BIT_HIGH;
            ST_BIT_HIGH: begin
                if (fall) begin
                    frame_d = {frame_q[FRAME_W-2:0], (us_cnt_q >= THRESH_CNT)};
                    if (idx_q == 6'(LAST_BIT_IDX)) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = ST_BIT_LOW;
                    end
                end
            end
            ST_CHECK: begin
                if (csum_pass) begin
                    hum_d  = frame_q[HUM_MSB -: 16];
                    temp_d = frame_q[TEMP_MSB -: 16];
                end
                ck_d    = csum_pass;
                to_d    = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // An edge seen in the same cycle as the limit still wins.
        if ((state_q inside {ST_WAIT_ACK, ST_ACK_LOW, ST_ACK_HIGH, ST_BIT_LOW, ST_BIT_HIGH})
            && (state_d == state_q) && (us_cnt_q >= TIMEOUT_CNT)) begin
            to_d    = 1'b1;
            ck_d    = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        us_cnt_d = us_cnt_q;
        if (state_chg) begin
            us_cnt_d = '0;
        end else if (tick && (us_cnt_q != 16'hFFFF)) begin
            us_cnt_d = us_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= ST_IDLE;
            us_cnt_q <= '0;
            hum_q    <= '0;
            temp_q   <= '0;
            ck_q     <= 1'b0;
            to_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            us_cnt_q <= us_cnt_d;
            hum_q    <= hum_d;
            temp_q   <= temp_d;
            ck_q     <= ck_d;
            to_q     <= to_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge ACLK) begin
        idx_q   <= idx_d;
        frame_q <= frame_d;
    end

    // busy covers the done cycle so a start coinciding with done is dropped
    assign busy        = (state_q != ST_IDLE) || done_q;
    assign done        = done_q;
    assign dht_oe      = (state_q == ST_START_LOW);
    assign humidity    = hum_q;
    assign temperature = temp_q;
    assign checksum_ok = ck_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_dht22_onewire_ctrl.sv
// Scoreboard bench for dht22_onewire_ctrl with a behavioural DHT22 sensor model.
// Glitch case is exercised only when DHT22_GLITCH_FILTER_EN is defined.
module tb_dht22_onewire_ctrl;

    localparam int CLK_HZ = 2_000_000;
    localparam int CYC    = CLK_HZ / 1_000_000;

    typedef struct packed {
        logic [15:0] hum;
        logic [15:0] temp;
        logic        ck;
        logic        to;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, checksum_ok, timeout_err, dht_oe;
    logic [15:0] humidity, temperature;
    logic        sens_low = 1'b0;
    logic        sens_active = 1'b0;
    wire         dht_i = ~(dht_oe | sens_low);

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   start_cyc = 0;
    int   last_rel_cyc = 0;
    exp_t sb[$];

    dht22_onewire_ctrl #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .START_LOW_US (10),
        .TIMEOUT_US   (200),
        .BIT_THRESH_US(48)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .humidity   (humidity),
        .temperature(temperature),
        .checksum_ok(checksum_ok),
        .timeout_err(timeout_err),
        .dht_i      (dht_i),
        .dht_oe     (dht_oe)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge ACLK) begin
        if (!ARESET && done) begin
            exp_t e;
            done_cnt++;
            done_cyc = cyc;
            check("busy_during_done", {31'd0, busy}, 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("humidity", {16'd0, humidity}, {16'd0, e.hum});
                check("temperature", {16'd0, temperature}, {16'd0, e.temp});
                check("checksum_ok", {31'd0, checksum_ok}, {31'd0, e.ck});
                check("timeout_err", {31'd0, timeout_err}, {31'd0, e.to});
            end
        end
    end

    initial begin
        repeat (95000) @(posedge ACLK);
        $display("FAIL watchdog: actual cycle %0d required finish earlier", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_us(input int us);
        repeat (us * CYC) @(negedge ACLK);
    endtask

    task automatic sensor_frame(input logic [39:0] f, input int nbits, input bit glitch);
        int t;
        sens_active = 1'b1;
        t = 0;
        while (!dht_oe && t < 1000) begin @(negedge ACLK); t++; end
        t = 0;
        while (dht_oe && t < 1000) begin @(negedge ACLK); t++; end
        wait_us(20);
        sens_low = 1'b1; wait_us(80);
        sens_low = 1'b0; wait_us(80);
        for (int i = 0; i < nbits; i++) begin
            sens_low = 1'b1; wait_us(50);
            sens_low = 1'b0;
            if (f[39-i]) begin
                if (glitch && i == 6) begin
                    wait_us(35);
                    sens_low = 1'b1; @(negedge ACLK);
                    sens_low = 1'b0; wait_us(35);
                end else begin
                    wait_us(70);
                end
            end else begin
                wait_us(27);
            end
        end
        sens_low = 1'b1; wait_us(50);
        sens_low = 1'b0;
        last_rel_cyc = cyc;
        sens_active = 1'b0;
    endtask

    task automatic do_start();
        @(negedge ACLK);
        check("idle_before_start", {31'd0, busy}, 32'd0);
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        start_cyc = cyc;
        check("start_to_busy", {31'd0, busy}, 32'd1);
        check("start_to_oe", {31'd0, dht_oe}, 32'd1);
    endtask

    task automatic wait_done(input int prev, input int bound);
        int t = 0;
        while (done_cnt == prev && t < bound) begin @(negedge ACLK); t++; end
        check("done_seen", {31'd0, done_cnt != prev}, 32'd1);
    endtask

    task automatic run_frame(input logic [39:0] f, input exp_t e, input bit glitch);
        int prev;
        sb.push_back(e);
        prev = done_cnt;
        do_start();
        sensor_frame(f, 40, glitch);
        wait_done(prev, 2000);
        repeat (10) @(negedge ACLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_oe"}, {31'd0, dht_oe}, 32'd0);
        check({tag, "_hum"}, {16'd0, humidity}, 32'd0);
        check({tag, "_temp"}, {16'd0, temperature}, 32'd0);
        check({tag, "_ck"}, {31'd0, checksum_ok}, 32'd0);
        check({tag, "_to"}, {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        int prev, n;
        bit ok;

        repeat (4) @(negedge ACLK);
        check_all_zero("reset");
        ARESET = 1'b0;
        repeat (4) @(negedge ACLK);

        // nominal frame: 02+8C+01+5F = EE
        run_frame(40'h028C015FEE, '{16'h028C, 16'h015F, 1'b1, 1'b0}, 1'b0);
        // bad checksum: values kept from the nominal frame
        run_frame(40'h028C015FEF, '{16'h028C, 16'h015F, 1'b0, 1'b0}, 1'b0);
        // negative temperature: 01+90+80+65 = 0x176 -> 76
        run_frame(40'h0190806576, '{16'h0190, 16'h8065, 1'b1, 1'b0}, 1'b0);

        // sensor silent: 10 us start pulse, then 200 us wait for the ack
        sb.push_back('{16'h0190, 16'h8065, 1'b0, 1'b1});
        prev = done_cnt;
        do_start();
        n = 0;
        while (dht_oe && n < 1000) begin n++; @(negedge ACLK); end
        check_range("start_low_cycles", n, CYC * 10, CYC * 11);
        wait_done(prev, 1000);
        check_range("no_answer_done_cycles", done_cyc - start_cyc, CYC * 209, CYC * 211 + 4);
        repeat (10) @(negedge ACLK);

        // sensor stops after bit 20; start is pulsed in the done cycle
        sb.push_back('{16'h0190, 16'h8065, 1'b0, 1'b1});
        prev = done_cnt;
        do_start();
        sensor_frame(40'h028C015FEE, 21, 1'b0);
        n = 0;
        while (!done && n < 1000) begin @(negedge ACLK); n++; end
        check("stop20_done_seen", {31'd0, done}, 32'd1);
        check_range("stop20_timeout_cycles", cyc - last_rel_cyc, CYC * 200, CYC * 201 + 6);
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        check("busy_drops_after_done", {31'd0, busy}, 32'd0);
        check("start_at_done_ignored", {31'd0, dht_oe}, 32'd0);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        repeat (10) @(negedge ACLK);

`ifdef DHT22_GLITCH_FILTER_EN
        run_frame(40'h028C015FEE, '{16'h028C, 16'h015F, 1'b1, 1'b0}, 1'b1);
`endif

        // start while busy is dropped; reset mid-frame aborts with no done
        do_start();
        fork
            sensor_frame(40'h028C015FEE, 40, 1'b0);
        join_none
        repeat (CYC * 700) @(negedge ACLK);
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (dht_oe || !busy) ok = 1'b0;
            @(negedge ACLK);
        end
        check("start_while_busy_ignored", {31'd0, ok}, 32'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        check_all_zero("abort");
        n = 0;
        while (sens_active && n < 20000) begin @(negedge ACLK); n++; end
        check("sensor_model_finished", {31'd0, sens_active}, 32'd0);
        repeat (10) @(negedge ACLK);

        // recovery after the abort
        run_frame(40'h028C015FEE, '{16'h028C, 16'h015F, 1'b1, 1'b0}, 1'b0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
